wbm_spi_host: RTL and testbench
===============================

// Module: wbm_spi_host
// PURPOSE
// SPI master (mode 0) that drives the opposite end of the SPI-to-Wishbone bridge byte protocol.
// Takes one parallel read/write request at a time and serialises the command, address and write data.
// Polls for the ACK byte, then collects the read data and returns one response per request.
// Used in FPGA-to-FPGA links and in benches as the "MCU" stand-in.
// PARAMETERS
// CLK_DIV   4    wb_clk_i cycles per SCK half-period (>=2)
// MAX_POLL  255  poll bytes clocked before giving up on ACK (1..255)
// CS_GAP    4    wb_clk_i cycles CSN stays high between transactions (>=1)
// PORTS
// wb_clk_i   in   1   system clock; sole clock domain
// wb_rst_i   in   1   asynchronous, active-high reset
// req_valid  in   1   request present
// req_ready  out  1   high only in IDLE; request accepted on req_valid&&req_ready
// req_we     in   1   1=write, 0=read
// req_sel    in   4   byte selects
// req_adr    in   8   word address (bridge maps it to Wishbone adr[9:2])
// req_dat    in   32  write data
// rsp_valid  out  1   one-cycle pulse, one per accepted request
// rsp_dat    out  32  read data (0 for writes/errors); held until next rsp_valid
// rsp_err    out  1   qualifies rsp_valid: ACK timeout or illegal request
// spi_sck    out  1   SPI clock, idle low
// spi_csn    out  1   chip select, active low, held low for the whole transaction
// spi_sdo    out  1   MOSI
// spi_sdi    in   1   MISO
// BEHAVIOUR
// Reset (async, immediate): spi_csn=1, spi_sck=0, spi_sdo=0, rsp_valid=0, rsp_err=0, rsp_dat=0, state=IDLE.
//   Reset mid-transfer aborts with no rsp_valid pulse.
// Byte engine: MSB first. SDO is set CLK_DIV cycles before each rising SCK edge.
//   SDI is sampled on the rising edge. A byte is 16*CLK_DIV cycles.
// Illegal request: req_we=0 with req_sel=0 would encode as 0x00, which the bridge discards.
//   It is accepted, produces no SPI activity, and pulses rsp_valid with rsp_err=1 one cycle after acceptance.
// States: IDLE -> CS_SETUP (CSN low, CLK_DIV cycles) -> CMD -> ADDR -> {WDATA0..3 | POLL} ... -> CS_HOLD -> GAP -> IDLE
// - CMD: send {req_we,3'b000,req_sel}. ADDR: send req_adr. Request fields are latched at acceptance.
// - WDATA0..3: send req_dat[31:24],[23:16],[15:8],[7:0] (MSB byte first), then POLL.
// - POLL: send 0x00 and compare the received byte.
//   Byte == 0x01 means ACK; any other value means stall.
//   Write: ACK -> CS_HOLD. Read: ACK -> RDATA0.
//   After MAX_POLL non-ACK bytes -> CS_HOLD with timeout flagged.
// - RDATA0..3: send 0x00. Received bytes are data[7:0],[15:8],[23:16],[31:24] (LSB byte first).
// - CS_HOLD: SCK low CLK_DIV cycles, then CSN high. GAP: CSN high CS_GAP cycles.
// rsp_valid pulses on the GAP->IDLE transition:
//   rsp_err = timeout; rsp_dat = assembled word (read, no error), else 0.
// req_ready deasserts the cycle after acceptance; requests offered while busy are ignored (not queued).
// Poll counter is 8 bits, cleared on POLL entry, and saturates at MAX_POLL. It never wraps.
// Timeout leaves the far end mid-cycle; recovery is the system's job, and this block performs no retry.
// SCK never toggles while CSN is high. SDO returns to 0 after each transaction.
// TESTING
// 1 Write we=1 sel=F adr=0x12 dat=0xDEADBEEF; model ACKs on poll byte 3
//   -> MOSI 0x8F,0x12,DE,AD,BE,EF,00,00,00; rsp_valid, err=0, dat=0
// 2 Read sel=F adr=0x34; model ACKs on poll byte 1, then sends EF,BE,AD,DE
//   -> MOSI 0x0F,0x34,00x5; rsp_dat=0xDEADBEEF, err=0
// 3 Read with model never ACKing, MAX_POLL=4
//   -> exactly 4 poll bytes; CSN rises; rsp_err=1, rsp_dat=0
// 4 Read sel=0 -> no SCK/CSN activity; rsp_valid with err=1 on the next cycle
// 5 Second request held during a busy write -> ignored until IDLE; each request yields exactly one rsp_valid
// 6 Assert wb_rst_i mid WDATA1 -> same cycle CSN=1, SCK=0; no rsp_valid; next request completes normally

Source files
------------

// File: rtl/wbm_spi_host.sv
// -----------------------------------------------------------------------------
// wbm_spi_host
//
// SPI master (mode 0) for the far end of the SPI-to-Wishbone bridge byte
// protocol. One parallel read/write request is accepted at a time. The
// request is sent as a command byte, an address byte and (for writes) four
// data bytes. The block then polls with 0x00 bytes until the bridge answers
// 0x01 (ACK). For reads, four data bytes are then collected, LSB byte first.
// Exactly one response is returned for every accepted request.
//
// Parameters
//   CLK_DIV   wb_clk_i cycles per SCK half-period (>=2)
//   MAX_POLL  non-ACK poll bytes tolerated before timing out (1..255)
//   CS_GAP    wb_clk_i cycles CSN stays high between transactions (>=1)
//
// Ports
//   wb_clk_i   system clock, sole clock domain
//   wb_rst_i   asynchronous active-high reset
//   req_*      request channel; accepted on req_valid && req_ready
//   rsp_valid  one-cycle response pulse; rsp_dat/rsp_err held until next pulse
//   spi_*      SPI mode 0 master pins (SCK idle low, CSN active low)
// -----------------------------------------------------------------------------
module wbm_spi_host #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_POLL = 255,
    parameter int CS_GAP   = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_sel,
    input  logic [7:0]  req_adr,
    input  logic [31:0] req_dat,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        spi_sck,
    output logic        spi_csn,
    output logic        spi_sdo,
    input  logic        spi_sdi
);

    // One counter serves the SCK half-period, the CS setup/hold and the gap.
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [7:0]       POLL_LAST = 8'(MAX_POLL - 1);
    localparam logic [7:0]       POLL_SAT  = 8'(MAX_POLL);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ILLEGAL,
        S_CS_SETUP,
        S_CMD,
        S_ADDR,
        S_WDATA0,
        S_WDATA1,
        S_WDATA2,
        S_WDATA3,
        S_POLL,
        S_RDATA0,
        S_RDATA1,
        S_RDATA2,
        S_RDATA3,
        S_CS_HOLD,
        S_GAP
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [7:0]       nxt_byte;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       poll_cnt;
    logic             timeout;
    logic             in_byte;
    logic             byte_done;
    logic             byte_ack;

    // Request fields latched at acceptance, and the assembled read word.
    logic             we_q;
    logic [3:0]       sel_q;
    logic [7:0]       adr_q;
    logic [31:0]      dat_q;
    logic [31:0]      rdata;
    logic [7:0]       cmd_byte;

    // Poll counter never wraps: it sticks at MAX_POLL.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v >= POLL_SAT) begin
            return v;
        end
        return v + 8'd1;
    endfunction

    assign req_ready = (state == S_IDLE);
    assign cmd_byte  = {we_q, 3'b000, sel_q};
    assign byte_ack  = (rx_sr == 8'h01);
    assign in_byte   = state inside {S_CMD, S_ADDR, S_WDATA0, S_WDATA1, S_WDATA2,
                                     S_WDATA3, S_POLL, S_RDATA0, S_RDATA1,
                                     S_RDATA2, S_RDATA3};
    // A byte ends on the falling SCK edge of its eighth bit.
    assign byte_done = in_byte && spi_sck && (cnt == DIV_LAST) && (bit_cnt == 3'd7);

    // Successor state and next byte to shift out when the current byte ends.
    always_comb begin
        nxt_state = state;
        nxt_byte  = 8'h00;
        case (state)
            S_CMD: begin
                nxt_state = S_ADDR;
                nxt_byte  = adr_q;
            end
            S_ADDR: begin
                if (we_q) begin
                    nxt_state = S_WDATA0;
                    nxt_byte  = dat_q[31:24];
                end else begin
                    nxt_state = S_POLL;
                end
            end
            S_WDATA0: begin
                nxt_state = S_WDATA1;
                nxt_byte  = dat_q[23:16];
            end
            S_WDATA1: begin
                nxt_state = S_WDATA2;
                nxt_byte  = dat_q[15:8];
            end
            S_WDATA2: begin
                nxt_state = S_WDATA3;
                nxt_byte  = dat_q[7:0];
            end
            S_WDATA3: nxt_state = S_POLL;
            S_POLL: begin
                if (byte_ack) begin
                    nxt_state = we_q ? S_CS_HOLD : S_RDATA0;
                end else if (poll_cnt >= POLL_LAST) begin
                    nxt_state = S_CS_HOLD;
                end else begin
                    nxt_state = S_POLL;
                end
            end
            S_RDATA0: nxt_state = S_RDATA1;
            S_RDATA1: nxt_state = S_RDATA2;
            S_RDATA2: nxt_state = S_RDATA3;
            S_RDATA3: nxt_state = S_CS_HOLD;
            default:  nxt_state = state;
        endcase
    end

    // Data-only registers; every read that completes without timeout writes
    // all four bytes of rdata before it is used.
    always_ff @(posedge wb_clk_i) begin
        if (req_valid && req_ready) begin
            we_q  <= req_we;
            sel_q <= req_sel;
            adr_q <= req_adr;
            dat_q <= req_dat;
        end
        if (byte_done) begin
            case (state)
                S_RDATA0: rdata[7:0]   <= rx_sr;
                S_RDATA1: rdata[15:8]  <= rx_sr;
                S_RDATA2: rdata[23:16] <= rx_sr;
                S_RDATA3: rdata[31:24] <= rx_sr;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            spi_csn   <= 1'b1;
            spi_sck   <= 1'b0;
            spi_sdo   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= 32'h0;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            tx_sr     <= 8'h00;
            rx_sr     <= 8'h00;
            poll_cnt  <= 8'h00;
            timeout   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        timeout <= 1'b0;
                        cnt     <= '0;
                        // Read with no byte selects encodes as 0x00, which
                        // the bridge ignores: answer locally with an error.
                        if (!req_we && (req_sel == 4'h0)) begin
                            state <= S_ILLEGAL;
                        end else begin
                            state   <= S_CS_SETUP;
                            spi_csn <= 1'b0;
                        end
                    end
                end
                S_ILLEGAL: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_dat   <= 32'h0;
                    state     <= S_IDLE;
                end
                S_CS_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= 3'd0;
                        tx_sr   <= cmd_byte;
                        spi_sdo <= cmd_byte[7];
                        state   <= S_CMD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CS_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= '0;
                        spi_csn <= 1'b1;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        state     <= S_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= timeout;
                        rsp_dat   <= (!we_q && !timeout) ? rdata : 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Byte engine: SDO changes on the falling edge (or at byte
                    // load), SDI is captured on the rising edge.
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], spi_sdi};
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                                spi_sdo <= tx_sr[6];
                            end else begin
                                bit_cnt <= 3'd0;
                                state   <= nxt_state;
                                if (nxt_state == S_CS_HOLD) begin
                                    tx_sr   <= 8'h00;
                                    spi_sdo <= 1'b0;
                                end else begin
                                    tx_sr   <= nxt_byte;
                                    spi_sdo <= nxt_byte[7];
                                end
                                if (state == S_POLL) begin
                                    if (!byte_ack) begin
                                        poll_cnt <= sat_inc(poll_cnt);
                                        if (poll_cnt >= POLL_LAST) begin
                                            timeout <= 1'b1;
                                        end
                                    end
                                end else if (nxt_state == S_POLL) begin
                                    poll_cnt <= 8'h00;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_spi_host.sv
// -----------------------------------------------------------------------------
// tb_wbm_spi_host
//
// Directed bench for wbm_spi_host. A behavioural SPI slave stands in for the
// bridge: it records every MOSI byte and plays back a per-transaction MISO
// byte string. Table vectors cover whole transactions; hand sequences cover
// the illegal request, a request held while busy, and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_wbm_spi_host;

    localparam int CLK_DIV  = 2;
    localparam int MAX_POLL = 4;
    localparam int CS_GAP   = 3;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_sel = 4'h0;
    logic [7:0]  req_adr = 8'h00;
    logic [31:0] req_dat = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        spi_sck;
    logic        spi_csn;
    logic        spi_sdo;
    logic        spi_sdi;

    always #5 wb_clk_i = ~wb_clk_i;

    wbm_spi_host #(
        .CLK_DIV  (CLK_DIV),
        .MAX_POLL (MAX_POLL),
        .CS_GAP   (CS_GAP)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_sel   (req_sel),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .spi_sck   (spi_sck),
        .spi_csn   (spi_csn),
        .spi_sdo   (spi_sdo),
        .spi_sdi   (spi_sdi)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SPI slave model ----------------
    logic [95:0] miso_v = 96'h0;     // byte 0 in [95:88]
    logic [7:0]  mosi_q [16];
    logic [7:0]  mosi_sr = 8'h00;
    int          mosi_n = 0;
    int          s_byte = 0;
    int          s_bit = 0;
    int          sck_rises = 0;
    int          csn_falls = 0;
    int          sck_bad = 0;
    logic        csn_prev = 1'b1;

    function automatic logic miso_at(input int b, input int k);
        if (b >= 12) return 1'b0;
        return miso_v[95 - 8*b - k];
    endfunction

    always @(negedge spi_csn or posedge spi_csn or posedge spi_sck or negedge spi_sck) begin
        if (spi_csn !== csn_prev) begin
            if (spi_csn === 1'b0) begin
                csn_falls++;
                mosi_n  = 0;
                s_byte  = 0;
                s_bit   = 0;
                spi_sdi = miso_at(0, 0);
            end
            csn_prev = spi_csn;
        end else if (spi_sck === 1'b1) begin
            sck_rises++;
            if (spi_csn !== 1'b0) sck_bad++;
            mosi_sr = {mosi_sr[6:0], spi_sdo};
            s_bit++;
            if (s_bit == 8) begin
                if (mosi_n < 16) mosi_q[mosi_n] = mosi_sr;
                mosi_n++;
                s_bit = 0;
                s_byte++;
            end
        end else begin
            spi_sdi = miso_at(s_byte, s_bit);
        end
    end

    function automatic logic [95:0] mosi_cap();
        logic [95:0] r = 96'h0;
        for (int i = 0; i < 12; i++) begin
            if (i < mosi_n) r[95 - 8*i -: 8] = mosi_q[i];
        end
        return r;
    endfunction

    int rsp_count = 0;
    always @(posedge wb_clk_i) if (rsp_valid === 1'b1) rsp_count++;

    // ---------------- helpers ----------------
    task automatic issue(input string name, input logic we, input logic [3:0] sel,
                         input logic [7:0] adr, input logic [31:0] dat);
        int n = 0;
        @(negedge wb_clk_i);
        req_we = we; req_sel = sel; req_adr = adr; req_dat = dat; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        check({name, "_accept"}, 128'(req_ready), 128'(1));
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check({name, "_rsp_seen"}, 128'(rsp_valid), 128'(1));
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [95:0] miso;
        int          n_mosi;
        logic [95:0] mosi;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int i);
        string nm = $sformatf("v%0d", i);
        miso_v = vecs[i].miso;
        issue(nm, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
        wait_rsp(nm);
        check({nm, "_err"},    128'(rsp_err), 128'(vecs[i].err));
        check({nm, "_dat"},    128'(rsp_dat), 128'(vecs[i].rdat));
        check({nm, "_nbytes"}, 128'(mosi_n),  128'(vecs[i].n_mosi));
        check({nm, "_mosi"},   128'(mosi_cap()), 128'(vecs[i].mosi));
        check({nm, "_csn"},    128'(spi_csn), 128'(1));
        check({nm, "_sdo"},    128'(spi_sdo), 128'(0));
        repeat (3) @(negedge wb_clk_i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int rc;
    int cf;
    int sr;

    initial begin
        vecs[0] = '{1'b1, 4'hF, 8'h12, 32'hDEADBEEF, 96'h000000000000FFFF01000000,
                    9, 96'h8F12DEADBEEF000000000000, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 4'hF, 8'h34, 32'h0, 96'h000001EFBEADDE0000000000,
                    7, 96'h0F3400000000000000000000, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 4'hF, 8'h34, 32'h0, 96'h0000FFFFFFFFFFFFFFFFFFFF,
                    6, 96'h0F3400000000000000000000, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 4'h3, 8'h55, 32'h12345678, 96'h000000000000010000000000,
                    7, 96'h835512345678000000000000, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 4'h1, 8'hA0, 32'h0, 96'h000000011122334400000000,
                    8, 96'h01A000000000000000000000, 1'b0, 32'h44332211};
        vecs[5] = '{1'b0, 4'hF, 8'hFF, 32'h0, 96'h0000FFFFFF01785634120000,
                    10, 96'h0FFF00000000000000000000, 1'b0, 32'h12345678};
        vecs[6] = '{1'b1, 4'h5, 8'h00, 32'h0, 96'h000000000000810100000000,
                    8, 96'h850000000000000000000000, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        check("rst_csn", 128'(spi_csn), 128'(1));
        check("rst_sck", 128'(spi_sck), 128'(0));
        check("rst_sdo", 128'(spi_sdo), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_err", 128'(rsp_err), 128'(0));
        check("rst_rsp_dat", 128'(rsp_dat), 128'(0));
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_ready", 128'(req_ready), 128'(1));

        for (int i = 0; i < 7; i++) run_vec(i);

        // Second request held while a write is in flight
        miso_v = 96'h000001EFBEAD010000000000;
        rc = rsp_count;
        cf = csn_falls;
        @(negedge wb_clk_i);
        req_we = 1'b1; req_sel = 4'hF; req_adr = 8'h40; req_dat = 32'hCAFEF00D; req_valid = 1'b1;
        check("busy_ready_idle", 128'(req_ready), 128'(1));
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req_we = 1'b0; req_sel = 4'hF; req_adr = 8'h34; req_dat = 32'h0;
        check("busy_ready_low", 128'(req_ready), 128'(0));
        wait_rsp("busy1");
        check("busy1_err", 128'(rsp_err), 128'(0));
        check("busy1_dat", 128'(rsp_dat), 128'(0));
        check("busy1_mosi", 128'(mosi_cap()), 128'(96'h8F40CAFEF00D000000000000));
        check("busy1_starts", 128'(csn_falls - cf), 128'(1));
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req_valid = 1'b0;
        check("busy2_taken", 128'(req_ready), 128'(0));
        wait_rsp("busy2");
        check("busy2_err", 128'(rsp_err), 128'(0));
        check("busy2_dat", 128'(rsp_dat), 128'(32'h01ADBEEF));
        check("busy2_mosi", 128'(mosi_cap()), 128'(96'h0F3400000000000000000000));
        repeat (40) @(negedge wb_clk_i);
        check("busy_rsp_count", 128'(rsp_count - rc), 128'(2));
        check("busy_starts", 128'(csn_falls - cf), 128'(2));

        // Illegal request: read with no byte selects
        sr = sck_rises;
        cf = csn_falls;
        @(negedge wb_clk_i);
        req_we = 1'b0; req_sel = 4'h0; req_adr = 8'h77; req_dat = 32'h0; req_valid = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        req_valid = 1'b0;
        check("ill_rsp_early", 128'(rsp_valid), 128'(0));
        check("ill_ready_low", 128'(req_ready), 128'(0));
        @(negedge wb_clk_i);
        check("ill_rsp_valid", 128'(rsp_valid), 128'(1));
        check("ill_rsp_err", 128'(rsp_err), 128'(1));
        check("ill_rsp_dat", 128'(rsp_dat), 128'(0));
        @(negedge wb_clk_i);
        check("ill_rsp_pulse", 128'(rsp_valid), 128'(0));
        repeat (10) @(negedge wb_clk_i);
        check("ill_no_sck", 128'(sck_rises - sr), 128'(0));
        check("ill_no_csn", 128'(csn_falls - cf), 128'(0));

        // Reset during WDATA1
        miso_v = vecs[0].miso;
        issue("rstmid", 1'b1, 4'hF, 8'h12, 32'hDEADBEEF);
        begin
            int n = 0;
            while (mosi_n < 3 && n < 500) begin
                @(negedge wb_clk_i);
                n++;
            end
        end
        check("rstmid_wdata1", 128'(mosi_n), 128'(3));
        repeat (4) @(negedge wb_clk_i);
        check("rstmid_csn_low", 128'(spi_csn), 128'(0));
        #2 wb_rst_i = 1'b1;
        #1;
        check("rstmid_csn", 128'(spi_csn), 128'(1));
        check("rstmid_sck", 128'(spi_sck), 128'(0));
        check("rstmid_sdo", 128'(spi_sdo), 128'(0));
        rc = rsp_count;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        check("rstmid_no_rsp", 128'(rsp_count - rc), 128'(0));
        check("rstmid_ready", 128'(req_ready), 128'(1));
        run_vec(1);

        check("sck_while_csn_high", 128'(sck_bad), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
